decode_stage_pipe: RTL

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_stage_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: instruction decode stage with register file, immediate
// extension, load-use hazard detection (IDLE/STALL FSM) and the ID/EX
// pipeline register.
// Optional feature: define DECODE_WB_BYPASS_EN to make a read that hits a
// same-cycle writeback return the new value (write-through). Without it the
// read returns the previously stored value.
module decode_stage_pipe #(
  parameter int DATA_W       = 32,
  parameter int NREG         = 32,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [31:0]       i_instruction,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ex_memread,
  input  logic [4:0]        i_ex_rt,
  input  logic [4:0]        i_dbg_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_rs_reg,
  output logic [DATA_W-1:0] o_rt_reg,
  output logic [4:0]        o_rs_addr,
  output logic [4:0]        o_rt_addr,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_imm,
  output logic [5:0]        o_op,
  output logic [5:0]        o_funct,
  output logic              o_stall,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  // Register count as a 6-bit value so 5-bit addresses compare at equal width.
  localparam logic [5:0] NREG_L   = 6'(NREG);
  localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES - 1);

  // Entries at or above NREG are never written and stay zero.
  logic [DATA_W-1:0] r_regs [32];
  logic [0:0]        r_state;
  logic [1:0]        r_cnt;

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [5:0]        w_funct;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_wb_ok;
  logic              w_hazard;
  logic              w_zext;

  assign w_op    = i_instruction[31:26];
  assign w_rs    = i_instruction[25:21];
  assign w_rt    = i_instruction[20:16];
  assign w_rd    = i_instruction[15:11];
  assign w_funct = i_instruction[5:0];

  // A writeback only lands on an existing, non-zero register.
  assign w_wb_ok = i_wb_we && (i_wb_addr != 5'd0) && ({1'b0, i_wb_addr} < NREG_L);

  // Read port: r0 and addresses beyond the register count read as zero.
  function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if ((a != 5'd0) && ({1'b0, a} < NREG_L)) begin
`ifdef DECODE_WB_BYPASS_EN
      if (w_wb_ok && (a == i_wb_addr)) v = i_wb_data;
      else                             v = r_regs[a];
`else
      v = r_regs[a];
`endif
    end
    return v;
  endfunction

  assign w_rs_val   = rd_port(w_rs);
  assign w_rt_val   = rd_port(w_rt);
  assign o_dbg_data = rd_port(i_dbg_addr);

  // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
  assign w_zext = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
  assign w_imm  = w_zext ? {{(DATA_W-16){1'b0}}, i_instruction[15:0]}
                         : {{(DATA_W-16){i_instruction[15]}}, i_instruction[15:0]};

  // Load-use hazard is only evaluated in IDLE; STALL covers the remaining bubbles.
  assign w_hazard = (r_state == S_IDLE) && i_valid && i_ex_memread &&
                    (i_ex_rt != 5'd0) && ((i_ex_rt == w_rs) || (i_ex_rt == w_rt));

  // Flush wins over any stall, and reset forces the pipeline enables on.
  assign o_stall       = i_rst_n && !i_flush && (w_hazard || (r_state == S_STALL));
  assign o_pc_write    = !o_stall;
  assign o_if_id_write = !o_stall;

  // Register file write; reset clears every entry.
  // NOTE: the array is in the async reset because the architecture requires
  // all registers to read zero after reset; this costs a true flop array.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_ok) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Stall FSM: a hazard in IDLE opens STALL_CYCLES-1 further bubble cycles.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hazard && (STALL_CYCLES > 1)) begin
            r_state <= S_STALL;
            r_cnt   <= CNT_INIT;
          end
        end
        default: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ID/EX register: flush clears, stall inserts a bubble and holds fields.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_pc      <= '0;
      o_rs_reg  <= '0;
      o_rt_reg  <= '0;
      o_rs_addr <= '0;
      o_rt_addr <= '0;
      o_rd_addr <= '0;
      o_imm     <= '0;
      o_op      <= '0;
      o_funct   <= '0;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      o_pc      <= '0;
      o_rs_reg  <= '0;
      o_rt_reg  <= '0;
      o_rs_addr <= '0;
      o_rt_addr <= '0;
      o_rd_addr <= '0;
      o_imm     <= '0;
      o_op      <= '0;
      o_funct   <= '0;
    end else if (o_stall) begin
      o_valid <= 1'b0;
    end else begin
      o_valid   <= i_valid;
      o_pc      <= i_pc;
      o_rs_reg  <= w_rs_val;
      o_rt_reg  <= w_rt_val;
      o_rs_addr <= w_rs;
      o_rt_addr <= w_rt;
      o_rd_addr <= w_rd;
      o_imm     <= w_imm;
      o_op      <= w_op;
      o_funct   <= w_funct;
    end
  end

endmodule
